// File: rtl/hdmi_island_pkg.sv
// Shared constants and encodings for the HDMI data-island scheduler and its packet arbiter.
package hdmi_island_pkg;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    typedef enum logic [1:0] {
        PKT_NULL  = 2'd0,
        PKT_ACR   = 2'd1,
        PKT_AUDIO = 2'd2,
        PKT_INFO  = 2'd3
    } pktType_t;

    localparam logic [1:0] IF_AVI   = 2'd0;
    localparam logic [1:0] IF_SPD   = 2'd1;
    localparam logic [1:0] IF_AUDIO = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_PREAMBLE,
        S_GUARD_LEAD,
        S_PACKET,
        S_GUARD_TRAIL,
        S_WAIT
    } islandState_t;

endpackage

// File: rtl/hdmi_packet_arbiter.sv
// Fixed-priority packet-slot select (ACR > audio > infoframe) and the per-frame infoframe pending mask.
module hdmi_packet_arbiter
    import hdmi_island_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frameStart,
    input  logic       acrRequest,
    input  logic       sampleFifoEmpty,
    input  logic       clearValid,
    input  logic [1:0] clearIndex,
    output logic       anyPending,
    output pktType_t   selType,
    output logic [1:0] selIndex
);

    logic [2:0] pendMask;
    logic [2:0] maskNext;

    // A new frame re-arms every infoframe, even one granted in the same cycle.
    always_comb begin
        maskNext = pendMask;
        if (clearValid) maskNext[clearIndex] = 1'b0;
        if (frameStart) maskNext = 3'b111;
    end

    always_ff @(posedge clk) begin
        if (reset) pendMask <= 3'b000;
        else       pendMask <= maskNext;
    end

    always_comb begin
        selType  = PKT_NULL;
        selIndex = IF_AVI;
        if (acrRequest)            selType = PKT_ACR;
        else if (!sampleFifoEmpty) selType = PKT_AUDIO;
        else if (pendMask[0])      begin selType = PKT_INFO; selIndex = IF_AVI;   end
        else if (pendMask[1])      begin selType = PKT_INFO; selIndex = IF_SPD;   end
        else if (pendMask[2])      begin selType = PKT_INFO; selIndex = IF_AUDIO; end
    end

    assign anyPending = acrRequest | ~sampleFifoEmpty | (|pendMask);

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Per-line data-island scheduler: opens an island in blanking, packs 32-cycle packets, drives encoder controls.
module hdmi_island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int H_BLANK     = 370,
    parameter int LEAD        = 4,
    parameter int TAIL        = 12,
    parameter int MAX_PACKETS = 18
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic       blankStart,
    input  logic       frameStart,
    input  logic       acrRequest,
    input  logic       sampleFifoEmpty,
    output logic       acrGrant,
    output logic       sampleFifoReadEnable,
    output logic       infoframeGrant,
    output logic [1:0] infoframeIndex,
    output logic       packetStart,
    output logic [1:0] packetType,
    output logic       islandPreamble,
    output logic       islandGuardBand,
    output logic       islandActive
);

    islandState_t state, stateNext;
    logic [8:0]   cycleCnt;
    logic [4:0]   pktCnt;
    logic [4:0]   phase;
    logic [9:0]   pktEnd;
    logic         budgetOk, boundary, admit, anyPending;
    pktType_t     selType;
    logic [1:0]   selIndex;

    hdmi_packet_arbiter uArb (
        .clk             (pixelClock),
        .reset           (reset),
        .frameStart      (frameStart),
        .acrRequest      (acrRequest),
        .sampleFifoEmpty (sampleFifoEmpty),
        .clearValid      (infoframeGrant),
        .clearIndex      (infoframeIndex),
        .anyPending      (anyPending),
        .selType         (selType),
        .selIndex        (selIndex)
    );

    // Cycle after trailing guard of packet pktCnt, plus the TAIL margin, must fit in blanking.
    assign pktEnd   = 10'(LEAD + PREAMBLE_LEN + GUARD_LEN + PACKET_LEN + GUARD_LEN + TAIL)
                    + {pktCnt, 5'd0};
    assign budgetOk = (pktEnd <= 10'(H_BLANK)) && (10'(pktCnt) < 10'(MAX_PACKETS));

    always_comb begin
        stateNext = state;
        boundary  = 1'b0;
        admit     = 1'b0;
        case (state)
            S_IDLE:        if (blankStart) stateNext = S_LEAD;
            S_LEAD:        if (cycleCnt == 9'(LEAD - 1))
                               stateNext = (anyPending && budgetOk) ? S_PREAMBLE : S_WAIT;
            S_PREAMBLE:    if (cycleCnt == 9'(LEAD + PREAMBLE_LEN - 1)) stateNext = S_GUARD_LEAD;
            S_GUARD_LEAD:  boundary = (cycleCnt == 9'(LEAD + PREAMBLE_LEN + GUARD_LEN - 1));
            S_PACKET:      boundary = (phase == 5'(PACKET_LEN - 1));
            S_GUARD_TRAIL: if (phase == 5'(GUARD_LEN - 1)) stateNext = S_WAIT;
            S_WAIT:        stateNext = S_IDLE;
            default:       stateNext = S_IDLE;
        endcase
        if (boundary) begin
            admit     = anyPending && budgetOk;
            stateNext = admit ? S_PACKET : S_GUARD_TRAIL;
        end
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state    <= S_IDLE;
            cycleCnt <= '0;
            pktCnt   <= '0;
            phase    <= '0;
        end else begin
            state <= stateNext;
            if (stateNext == S_IDLE)  cycleCnt <= '0;
            else if (cycleCnt != '1)  cycleCnt <= cycleCnt + 9'd1;
            if (state == S_IDLE)      pktCnt <= '0;
            else if (admit)           pktCnt <= pktCnt + 5'd1;
            if (stateNext != state || admit) phase <= '0;
            else                             phase <= phase + 5'd1;
        end
    end

    // Outputs decode the next state so each flop is valid in the cycle that state occupies.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            acrGrant             <= 1'b0;
            sampleFifoReadEnable <= 1'b0;
            infoframeGrant       <= 1'b0;
            infoframeIndex       <= 2'd0;
            packetStart          <= 1'b0;
            packetType           <= 2'd0;
            islandPreamble       <= 1'b0;
            islandGuardBand      <= 1'b0;
            islandActive         <= 1'b0;
        end else begin
            acrGrant             <= admit && (selType == PKT_ACR);
            sampleFifoReadEnable <= admit && (selType == PKT_AUDIO);
            infoframeGrant       <= admit && (selType == PKT_INFO);
            infoframeIndex       <= (admit && selType == PKT_INFO) ? selIndex : 2'd0;
            packetStart          <= admit;
            if (admit)                        packetType <= selType;
            else if (stateNext != S_PACKET)   packetType <= PKT_NULL;
            islandPreamble       <= (stateNext == S_PREAMBLE);
            islandGuardBand      <= (stateNext == S_GUARD_LEAD) || (stateNext == S_GUARD_TRAIL);
            islandActive         <= (stateNext == S_PACKET);
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Scoreboard bench: a line-level schedule model predicts every output cycle; a monitor compares each cycle.
module tb_hdmi_island_scheduler;

    localparam int H_BLANK  = 370;
    localparam int LEAD     = 4;
    localparam int TAIL     = 12;
    localparam int MAXP     = 18;
    localparam int LINE_LEN = H_BLANK + 20;

    typedef struct packed {
        logic       acrG;
        logic       rdEn;
        logic       ifG;
        logic [1:0] ifIdx;
        logic       pStart;
        logic [1:0] pType;
        logic       pre;
        logic       guard;
        logic       act;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       blankStart = 1'b0, frameStart = 1'b0, acrRequest = 1'b0, sampleFifoEmpty = 1'b1;
    logic       acrGrant, sampleFifoReadEnable, infoframeGrant, packetStart;
    logic       islandPreamble, islandGuardBand, islandActive;
    logic [1:0] infoframeIndex, packetType;

    hdmi_island_scheduler #(.H_BLANK(H_BLANK), .LEAD(LEAD), .TAIL(TAIL), .MAX_PACKETS(MAXP)) dut (
        .pixelClock           (clk),
        .reset                (reset),
        .blankStart           (blankStart),
        .frameStart           (frameStart),
        .acrRequest           (acrRequest),
        .sampleFifoEmpty      (sampleFifoEmpty),
        .acrGrant             (acrGrant),
        .sampleFifoReadEnable (sampleFifoReadEnable),
        .infoframeGrant       (infoframeGrant),
        .infoframeIndex       (infoframeIndex),
        .packetStart          (packetStart),
        .packetType           (packetType),
        .islandPreamble       (islandPreamble),
        .islandGuardBand      (islandGuardBand),
        .islandActive         (islandActive)
    );

    always #5 clk = ~clk;

    outs_t expQ[$];
    int    tagQ[$];
    int    vectors = 0, miscompares = 0;
    int    lineNo = 0;

    outs_t expL[LINE_LEN];
    bit    bsA[LINE_LEN], fsA[LINE_LEN], acrA[LINE_LEN], empA[LINE_LEN], rstA[LINE_LEN];
    logic [2:0] mdlMask = 3'b000;

    // Schedule model: island opens at LEAD-1 if anything is pending; packet k sits at LEAD+10+32k.
    task automatic buildLine(input bit acrWant, input int acrRise, input int emptyPct,
                             input int fs1, input int fs2, input int rstAt, input int extraBs);
        int  k, nextDec, p;
        bit  acrDone, dead, pend;
        k = 0; nextDec = -1; acrDone = 0; dead = 0;
        for (int c = 0; c < LINE_LEN; c++) begin
            expL[c] = '0;
            bsA[c]  = (c == 0) || (c == extraBs);
            fsA[c]  = (c == fs1) || (c == fs2);
            rstA[c] = (c == rstAt);
            empA[c] = ($urandom_range(99) < emptyPct);
        end
        for (int c = 0; c < LINE_LEN; c++) begin
            acrA[c] = acrWant && (c >= acrRise) && !acrDone;
            pend = acrA[c] || !empA[c] || (mdlMask != 3'b000);
            if (!dead && c == LEAD - 1) begin
                if (pend && (LEAD + 10 + 46 <= H_BLANK)) begin
                    for (int n = LEAD; n < LEAD + 8; n++) expL[n].pre = 1'b1;
                    expL[LEAD + 8].guard = 1'b1;
                    expL[LEAD + 9].guard = 1'b1;
                    nextDec = LEAD + 9;
                end
            end else if (!dead && c == nextDec) begin
                p = c + 1;
                if ((p + 32 + 2 + TAIL <= H_BLANK) && (k < MAXP) && pend) begin
                    logic [1:0] t;
                    expL[p].pStart = 1'b1;
                    if (acrA[c]) begin t = 2'd1; expL[p].acrG = 1'b1; end
                    else if (!empA[c]) begin t = 2'd2; expL[p].rdEn = 1'b1; end
                    else begin
                        t = 2'd3; expL[p].ifG = 1'b1;
                        if (mdlMask[0])      expL[p].ifIdx = 2'd0;
                        else if (mdlMask[1]) expL[p].ifIdx = 2'd1;
                        else                 expL[p].ifIdx = 2'd2;
                    end
                    for (int j = 0; j < 32; j++) begin expL[p + j].pType = t; expL[p + j].act = 1'b1; end
                    k++;
                    nextDec = p + 31;
                end else begin
                    expL[p].guard = 1'b1;
                    expL[p + 1].guard = 1'b1;
                    nextDec = -1;
                end
            end
            if (rstA[c]) begin
                for (int j = c + 1; j < LINE_LEN; j++) expL[j] = '0;
                dead = 1;
            end
            if (expL[c].acrG) acrDone = 1;
            if (rstA[c]) mdlMask = 3'b000;
            else begin
                if (expL[c].ifG) mdlMask[expL[c].ifIdx] = 1'b0;
                if (fsA[c]) mdlMask = 3'b111;
            end
        end
    endtask

    task automatic runLine(input bit acrWant, input int acrRise, input int emptyPct,
                           input int fs1, input int fs2, input int rstAt, input int extraBs);
        buildLine(acrWant, acrRise, emptyPct, fs1, fs2, rstAt, extraBs);
        lineNo++;
        for (int c = 0; c < LINE_LEN; c++) begin
            @(posedge clk); #1;
            blankStart      = bsA[c];
            frameStart      = fsA[c];
            acrRequest      = acrA[c];
            sampleFifoEmpty = empA[c];
            reset           = rstA[c];
            expQ.push_back(expL[c]);
            tagQ.push_back(lineNo * 1000 + c);
        end
    endtask

    initial begin : monitor
        outs_t e, a;
        int    tag;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                tag = tagQ.pop_front();
                a   = {acrGrant, sampleFifoReadEnable, infoframeGrant, infoframeIndex,
                       packetStart, packetType, islandPreamble, islandGuardBand, islandActive};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs line%0d cyc%0d actual=%b required=%b (acr rd if idx st typ pre gb act)",
                             tag / 1000, tag % 1000, a, e);
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            reset = 1'b1;
            expQ.push_back('0);
            tagQ.push_back(i);
        end
        runLine(0, 0, 100, -1, -1, -1, -1);   // nothing pending: island stays closed
        runLine(1, 0, 100, -1, -1, -1, 2);    // single ACR, stray blankStart during LEAD
        runLine(0, 0, 0,   1,  -1, -1, -1);   // audio fills all 10 slots, mask armed
        runLine(0, 0, 100, -1, -1, -1, -1);   // three infoframes in index order
        runLine(1, 0, 0,   -1, -1, -1, -1);   // ACR beats audio
        runLine(0, 0, 100, 1,  14, -1, -1);   // frameStart coincident with AVI grant
        runLine(0, 0, 0,   -1, -1, 50, -1);   // reset mid-packet
        runLine(1, 0, 0,   -1, -1, -1, -1);   // normal scheduling after reset
        for (int l = 0; l < 30; l++) begin
            int pcts[4] = '{0, 50, 90, 100};
            int fs, rs;
            fs = ($urandom_range(2) == 0) ? int'($urandom_range(360)) : -1;
            rs = ($urandom_range(7) == 0) ? int'($urandom_range(5, 360)) : -1;
            runLine(1'($urandom_range(1)), int'($urandom_range(300)), pcts[$urandom_range(3)],
                    fs, -1, rs, -1);
        end
        @(posedge clk); #1;
        blankStart = 0; frameStart = 0; acrRequest = 0; sampleFifoEmpty = 1; reset = 0;
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            miscompares++;
            $display("FAIL drain actual=%0d pending required=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
